// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the dual-port RAM write/read-back engine.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    // Callers truncate the result to their word width; the sum wraps naturally there.
    function automatic logic [31:0] pat(input logic [31:0] addr, input logic [31:0] seed,
                                        input logic mode);
        logic [31:0] sum;
        sum = addr + seed;
        return mode ? ~sum : sum;
    endfunction

    function automatic bit rd_lat_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/ram_2port_bist_sdp_ram.sv
// Inferred simple dual-port RAM: port A writes, port B reads synchronously.
// RD_LAT=2 adds an output register behind the array read.
module sdp_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              ena,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    input  logic              enb,
    input  logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] doutb
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (ena && wea) begin
            mem[addra] <= dina;
        end
        if (enb) begin
            rd_q <= mem[addrb];
        end
    end

    if (RD_LAT == 2) begin : g_out_reg
        logic [DATA_W-1:0] out_q;
        always_ff @(posedge clk) begin
            out_q <= rd_q;
        end
        assign doutb = out_q;
    end else begin : g_no_out_reg
        assign doutb = rd_q;
    end

endmodule

// File: rtl/ram_2port_bist.sv
// Self-checking write/read-back engine: fills the RAM with a seeded pattern,
// reads it back and reports pass/fail, first failing address and error count.
module ram_2port_bist
    import ram_bist_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic              loop_en,
    input  logic              inj_en,
    input  logic [ADDR_W-1:0] inj_addr,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] err_addr,
    output logic [15:0]       pass_cnt
);

    if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
        $error("ram_2port_bist: RD_LAT must be 1 or 2");
    end

    state_t state, state_nxt;

    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_inc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] seed;
    logic              mode_q;
    logic [DATA_W-1:0] pat_word;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] doutb;
    logic              wr_en;
    logic              rd_en;
    logic              mismatch;

    logic [RD_LAT-1:0]             vld_pipe;
    logic [RD_LAT-1:0][DATA_W-1:0] exp_pipe;
    logic [RD_LAT-1:0][ADDR_W-1:0] adr_pipe;

    assign cnt_inc  = cnt + 1'b1;
    assign addr     = cnt[ADDR_W-1:0];
    assign pat_word = DATA_W'(pat(32'(addr), 32'(seed), mode_q));
    assign dina     = pat_word ^ DATA_W'(inj_en && (addr == inj_addr));
    assign wr_en    = (state == WRITE);
    assign rd_en    = (state == READ);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign mismatch = vld_pipe[RD_LAT-1] && (doutb != exp_pipe[RD_LAT-1]);

    // The MSB of the incremented counter flags the last address of a sweep.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = WRITE;
            WRITE: if (cnt_inc[ADDR_W]) state_nxt = READ;
            READ:  if (cnt_inc[ADDR_W]) state_nxt = DRAIN;
            DRAIN: if (cnt == (ADDR_W+1)'(RD_LAT-1)) state_nxt = DONE;
            DONE:  state_nxt = loop_en ? WRITE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state || state == IDLE) ? '0 : cnt_inc;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_pipe <= '0;
            exp_pipe <= '0;
            adr_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_en;
            exp_pipe[0] <= pat_word;
            adr_pipe[0] <= addr;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                exp_pipe[i] <= exp_pipe[i-1];
                adr_pipe[i] <= adr_pipe[i-1];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            seed     <= '0;
            mode_q   <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            err_addr <= '0;
            pass_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                mode_q <= mode;
            end
            if (state != WRITE && state_nxt == WRITE) begin
                err_cnt  <= '0;
                err_addr <= '0;
            end else if (mismatch) begin
                if (err_cnt == '0) begin
                    err_addr <= adr_pipe[RD_LAT-1];
                end
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
            if (state == DONE) begin
                pass     <= (err_cnt == '0);
                pass_cnt <= pass_cnt + 1'b1;
                seed     <= seed + 1'b1;
            end
        end
    end

    sdp_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) u_ram (
        .clk  (sys_clk),
        .ena  (wr_en),
        .wea  (wr_en),
        .addra(addr),
        .dina (dina),
        .enb  (rd_en),
        .addrb(addr),
        .doutb(doutb)
    );

endmodule

// File: tb/tb_ram_2port_bist.sv
// Bench for ram_2port_bist: a pass-level model checks the default instance every
// cycle; directed vectors cover latency, patterns, injection, looping, reset and a small config.
module tb_ram_2port_bist;

    localparam int D1    = 64;
    localparam int PASS1 = 2*D1 + 1 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    logic        rst1_n = 1'b0, start1 = 1'b0, mode1 = 1'b0, loop1 = 1'b0, inj_en1 = 1'b0;
    logic [5:0]  inj_addr1 = '0;
    logic        busy1, done1, pass1;
    logic [7:0]  err_cnt1;
    logic [5:0]  err_addr1;
    logic [15:0] pass_cnt1;

    logic        rst2_n = 1'b0, start2 = 1'b0, mode2 = 1'b0, loop2 = 1'b0, inj_en2 = 1'b0;
    logic [3:0]  inj_addr2 = '0;
    logic        busy2, done2, pass2;
    logic [1:0]  err_cnt2;
    logic [3:0]  err_addr2;
    logic [15:0] pass_cnt2;

    ram_2port_bist d1 (
        .sys_clk(clk), .sys_rst_n(rst1_n), .start(start1), .mode(mode1), .loop_en(loop1),
        .inj_en(inj_en1), .inj_addr(inj_addr1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err_cnt1), .err_addr(err_addr1), .pass_cnt(pass_cnt1)
    );

    ram_2port_bist #(.DATA_W(3), .ADDR_W(4), .RD_LAT(2), .ERR_W(2)) d2 (
        .sys_clk(clk), .sys_rst_n(rst2_n), .start(start2), .mode(mode2), .loop_en(loop2),
        .inj_en(inj_en2), .inj_addr(inj_addr2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err_cnt2), .err_addr(err_addr2), .pass_cnt(pass_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_word(input int a, input int s, input bit m, input int w);
        int v;
        v = (a + s) % (1 << w);
        if (m) v = (~v) & ((1 << w) - 1);
        return v;
    endfunction

    // Pass-level model of the default instance: m_t is the cycle number within a pass.
    int m_t = 0, m_seed = 0, m_pass_cnt = 0, m_err = 0, m_err_addr = 0;
    bit m_mode = 1'b0, m_pass = 1'b0;
    int mm [D1];

    always @(posedge clk or negedge rst1_n) begin
        if (!rst1_n) begin
            m_t = 0; m_seed = 0; m_mode = 0; m_pass_cnt = 0; m_pass = 0; m_err = 0; m_err_addr = 0;
        end else if (m_t == 0) begin
            if (start1) begin
                m_t = 1; m_mode = mode1; m_err = 0; m_err_addr = 0;
            end
        end else if (m_t == PASS1) begin
            m_pass     = (m_err == 0);
            m_pass_cnt = (m_pass_cnt + 1) % 65536;
            m_seed     = (m_seed + 1) % 256;
            if (loop1) begin
                m_t = 1; m_err = 0; m_err_addr = 0;
            end else begin
                m_t = 0;
            end
        end else begin
            if (m_t <= D1)
                mm[m_t-1] = exp_word(m_t-1, m_seed, m_mode, 8) ^ int'(inj_en1 && inj_addr1 == 6'(m_t-1));
            m_t++;
            if (m_t == PASS1) begin
                int n, first;
                n = 0; first = -1;
                for (int a = 0; a < D1; a++) begin
                    if (mm[a] != exp_word(a, m_seed, m_mode, 8)) begin
                        n++;
                        if (first < 0) first = a;
                    end
                end
                m_err      = (n > 255) ? 255 : n;
                m_err_addr = (first < 0) ? 0 : first;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", busy1, m_t != 0);
            chk("done", done1, m_t == PASS1);
            chk("pass", pass1, m_pass);
            chk("pass_cnt", pass_cnt1, m_pass_cnt);
            if (m_t <= D1 || m_t == PASS1) begin
                chk("err_cnt", err_cnt1, m_err);
                chk("err_addr", err_addr1, m_err_addr);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one cycle after the start pulse was sampled.
    task automatic pulse_start1();
        step();
        start1 = 1'b1;
        step();
        start1 = 1'b0;
    endtask

    task automatic pulse_start2();
        step();
        start2 = 1'b1;
        step();
        start2 = 1'b0;
    endtask

    // n = cycle index of done, counting the start cycle as index 0.
    task automatic wait_done1(input int from, output int n);
        n = from;
        while (!done1 && n < 1000) begin
            step();
            n++;
        end
    endtask

    task automatic wait_done2(input int from, output int n);
        n = from;
        while (!done2 && n < 1000) begin
            step();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        repeat (3) step();
        chk("rst_busy", busy1, 0);
        chk("rst_pass_cnt", pass_cnt1, 0);
        rst1_n = 1'b1;
        rst2_n = 1'b1;
        chk_on = 1'b1;

        // 1: mode 0, seed 0
        pulse_start1();
        wait_done1(1, lat);
        chk("t1_latency", lat, 130);
        chk("t1_ram5", d1.u_ram.mem[5], 8'h05);
        step();
        chk("t1_pass", pass1, 1);
        chk("t1_err_cnt", err_cnt1, 0);
        chk("t1_pass_cnt", pass_cnt1, 1);

        // 2: mode 1, seed 1; a start during DONE is ignored
        mode1 = 1'b1;
        pulse_start1();
        wait_done1(1, lat);
        chk("t2_ram5", d1.u_ram.mem[5], 8'hF9);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("t2_start_in_done", busy1, 0);
        chk("t2_pass", pass1, 1);
        chk("t2_pass_cnt", pass_cnt1, 2);

        // 3: one corrupted write, then a clean pass
        mode1 = 1'b0;
        inj_en1 = 1'b1;
        inj_addr1 = 6'd17;
        pulse_start1();
        wait_done1(1, lat);
        chk("t3_err_cnt", err_cnt1, 1);
        chk("t3_err_addr", err_addr1, 17);
        step();
        chk("t3_pass", pass1, 0);
        inj_en1 = 1'b0;
        pulse_start1();
        wait_done1(1, lat);
        step();
        chk("t3_clean_pass", pass1, 1);

        // 4: loop mode for three passes
        rst1_n = 1'b0;
        step();
        step();
        rst1_n = 1'b1;
        loop1 = 1'b1;
        pulse_start1();
        wait_done1(1, lat);
        chk("t4_first_latency", lat, 130);
        step();
        wait_done1(1, lat);
        chk("t4_gap1", lat, 130);
        step();
        loop1 = 1'b0;
        wait_done1(1, lat);
        chk("t4_gap2", lat, 130);
        step();
        chk("t4_idle_busy", busy1, 0);
        chk("t4_pass_cnt", pass_cnt1, 3);

        // 5: reset in the middle of READ
        pulse_start1();
        repeat (89) step();
        rst1_n = 1'b0;
        #1;
        chk("t5_busy_in_reset", busy1, 0);
        chk("t5_err_in_reset", err_cnt1, 0);
        chk("t5_pass_cnt_in_reset", pass_cnt1, 0);
        step();
        step();
        rst1_n = 1'b1;
        pulse_start1();
        wait_done1(1, lat);
        chk("t5_restart_latency", lat, 130);
        step();
        chk("t5_restart_pass", pass1, 1);

        // 6: RD_LAT=2, ADDR_W=4, DATA_W=3, ERR_W=2
        pulse_start2();
        wait_done2(1, lat);
        chk("t6_latency", lat, 35);
        chk("t6_ram5", d2.u_ram.mem[5], 3'd5);
        chk("t6_ram9_wrap", d2.u_ram.mem[9], 3'd1);
        step();
        chk("t6_pass", pass2, 1);
        chk("t6_pass_cnt", pass_cnt2, 1);
        inj_en2 = 1'b1;
        pulse_start2();
        for (int k = 0; k < 16; k++) begin
            inj_addr2 = 4'(k);
            step();
        end
        inj_en2 = 1'b0;
        wait_done2(17, lat);
        chk("t6_sat_latency", lat, 35);
        chk("t6_err_sat", err_cnt2, 3);
        chk("t6_err_addr", err_addr2, 0);
        step();
        chk("t6_sat_pass", pass2, 0);
        chk("t6_busy", busy2, 0);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
